// File: rtl/y86_pkg.sv
// Shared Y86 condition-code definitions: ifun codes, CC bit positions
// and the packed {ZF,SF,OF} type used across the execute stage.
package y86_pkg;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef logic [2:0] cc_t;

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluator.
// Maps {cc, ifun} to a condition bit and an illegal-ifun flag.
module y86_cond_eval
  import y86_pkg::*;
(
  input  cc_t        i_cc,
  input  logic [3:0] i_ifun,
  output logic       o_cnd,
  output logic       o_err
);

  logic w_zf;
  logic w_lt;

  assign w_zf = i_cc[CC_ZF];
  assign w_lt = i_cc[CC_SF] ^ i_cc[CC_OF];

  // Decode the ifun into the selected flag expression.
  always_comb begin
    o_cnd = 1'b0;
    o_err = 1'b0;
    case (i_ifun)
      C_ALWAYS: o_cnd = 1'b1;
      C_LE:     o_cnd = w_lt | w_zf;
      C_L:      o_cnd = w_lt;
      C_E:      o_cnd = w_zf;
      C_NE:     o_cnd = ~w_zf;
      C_GE:     o_cnd = ~w_lt;
      C_G:      o_cnd = ~w_lt & ~w_zf;
      default:  o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/y86_cc_unit.sv
// Y86 execute-stage condition-code unit with one-deep checkpoint.
// Define CC_BYPASS_EN to let same-cycle set_cc/restore feed the evaluator.
module y86_cc_unit
  import y86_pkg::*;
#(
  parameter int  WIDTH    = 64,
  parameter cc_t CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             set_cc,
  input  logic             stall,
  input  logic             checkpoint,
  input  logic             restore,
  input  logic             cnd_req,
  input  logic [3:0]       cnd_ifun,
  output logic [2:0]       cc_out,
  output logic             cnd_valid,
  output logic             cnd,
  output logic             cnd_err
);

  cc_t  r_cc;
  cc_t  r_shadow;
  cc_t  w_new;
  cc_t  w_eval_cc;
  logic w_cnd;
  logic w_err;

  assign w_new[CC_ZF] = (alu_result == '0);
  assign w_new[CC_SF] = alu_result[WIDTH-1];
  assign w_new[CC_OF] = alu_overflow;

`ifdef CC_BYPASS_EN
  // Evaluate against the value CC is about to take this edge.
  always_comb begin
    w_eval_cc = r_cc;
    if (restore)
      w_eval_cc = r_shadow;
    else if (set_cc)
      w_eval_cc = w_new;
  end
`else
  assign w_eval_cc = r_cc;
`endif

  y86_cond_eval u_eval (
    .i_cc   (w_eval_cc),
    .i_ifun (cnd_ifun),
    .o_cnd  (w_cnd),
    .o_err  (w_err)
  );

  // CC and shadow update; checkpoint+restore swaps the two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cc     <= CC_RESET;
      r_shadow <= CC_RESET;
    end else if (!stall) begin
      if (restore)
        r_cc <= r_shadow;
      else if (set_cc)
        r_cc <= w_new;
      if (checkpoint)
        r_shadow <= r_cc;
    end
  end

  // Registered condition response, one cycle after the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnd_valid <= 1'b0;
      cnd       <= 1'b0;
      cnd_err   <= 1'b0;
    end else if (!stall) begin
      cnd_valid <= cnd_req;
      if (cnd_req) begin
        cnd     <= w_cnd;
        cnd_err <= w_err;
      end
    end
  end

  assign cc_out = r_cc;

endmodule

// File: tb/tb_y86_cc_unit.sv
// Self-checking bench for y86_cc_unit: directed scenarios plus random
// stimulus against a flag-level reference model.
module tb_y86_cc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] alu_result = '0;
  logic        alu_overflow = 1'b0;
  logic        set_cc = 1'b0;
  logic        stall = 1'b0;
  logic        checkpoint = 1'b0;
  logic        restore = 1'b0;
  logic        cnd_req = 1'b0;
  logic [3:0]  cnd_ifun = '0;
  logic [2:0]  cc_out;
  logic        cnd_valid;
  logic        cnd;
  logic        cnd_err;

  int errors = 0;
  int checks = 0;

  logic [2:0] m_cc, m_sh;
  logic       m_valid, m_cnd, m_err;

  y86_cc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .set_cc       (set_cc),
    .stall        (stall),
    .checkpoint   (checkpoint),
    .restore      (restore),
    .cnd_req      (cnd_req),
    .cnd_ifun     (cnd_ifun),
    .cc_out       (cc_out),
    .cnd_valid    (cnd_valid),
    .cnd          (cnd),
    .cnd_err      (cnd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] flags_of(input logic [63:0] r,
                                          input logic o);
    logic z, s;
    z = (r == 64'd0);
    s = ($signed(r) < 0);
    return {z, s, o};
  endfunction

  // Returns {cnd, err} from the textbook condition table.
  function automatic logic [1:0] ref_cond(input logic [2:0] c,
                                          input logic [3:0] f);
    bit z, lt;
    z  = c[2];
    lt = (c[1] != c[0]);
    case (f)
      4'd0: return 2'b10;
      4'd1: return {lt || z, 1'b0};
      4'd2: return {lt, 1'b0};
      4'd3: return {z, 1'b0};
      4'd4: return {!z, 1'b0};
      4'd5: return {!lt, 1'b0};
      4'd6: return {!lt && !z, 1'b0};
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    m_cc = 3'b100; m_sh = 3'b100;
    m_valid = 0; m_cnd = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [2:0] nf, ev, ncc, nsh;
    logic [1:0] r;
    if (stall) return;
    nf = flags_of(alu_result, alu_overflow);
    ev = m_cc;
`ifdef CC_BYPASS_EN
    if (restore) ev = m_sh;
    else if (set_cc) ev = nf;
`endif
    m_valid = cnd_req;
    if (cnd_req) begin
      r = ref_cond(ev, cnd_ifun);
      m_cnd = r[1]; m_err = r[0];
    end
    ncc = restore ? m_sh : (set_cc ? nf : m_cc);
    nsh = checkpoint ? m_cc : m_sh;
    m_cc = ncc; m_sh = nsh;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    set_cc = 0; stall = 0; checkpoint = 0; restore = 0;
    cnd_req = 0; cnd_ifun = 0; alu_overflow = 0; alu_result = '0;
  endtask

  task automatic load(input logic [63:0] r, input logic o);
    idle();
    set_cc = 1; alu_result = r; alu_overflow = o;
    tick();
    idle();
  endtask

  task automatic req(input logic [3:0] f);
    idle();
    cnd_req = 1; cnd_ifun = f;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    model_reset();
    load(-64'sd1, 0);
    cnd_req = 1; cnd_ifun = 4'd3;
    #2 rst = 1;
    #1;
    checks++;
    if (cc_out !== 3'b100 || cnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_async cc=%b valid=%b want cc=100 valid=0",
               cc_out, cnd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (cnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_lost_req valid=%b want 0", cnd_valid);
    end
    rst = 0;
    model_reset();
    req(4'd3);
    checks++;
    if (cnd_valid !== 1'b1 || cnd !== 1'b1) begin
      errors++;
      $display("FAIL reset_e valid=%b cnd=%b want 1 1", cnd_valid, cnd);
    end
    tick();
  endtask

  task automatic test_flags();
    load(-64'sd610, 0);
    checks++;
    if (cc_out !== 3'b010) begin
      errors++;
      $display("FAIL flags_neg cc=%b want 010", cc_out);
    end
    req(4'd2);
    checks++;
    if (cnd !== 1'b1 || cnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL flags_l cnd=%b valid=%b want 1 1", cnd, cnd_valid);
    end
    req(4'd6);
    checks++;
    if (cnd !== 1'b0) begin
      errors++;
      $display("FAIL flags_g cnd=%b want 0", cnd);
    end
    load(64'd0, 0);
    checks++;
    if (cc_out !== 3'b100) begin
      errors++;
      $display("FAIL flags_zero cc=%b want 100", cc_out);
    end
    load(64'h579B579B579B579A, 1);
    checks++;
    if (cc_out !== 3'b001) begin
      errors++;
      $display("FAIL flags_ovf cc=%b want 001", cc_out);
    end
    req(4'd5);
    checks++;
    if (cnd !== 1'b0) begin
      errors++;
      $display("FAIL flags_ge cnd=%b want 0", cnd);
    end
  endtask

  task automatic test_checkpoint();
    load(-64'sd610, 0);
    idle(); checkpoint = 1; tick(); idle();
    load(64'd20356, 0);
    checks++;
    if (cc_out !== 3'b000) begin
      errors++;
      $display("FAIL ckpt_load cc=%b want 000", cc_out);
    end
    idle(); restore = 1; tick(); idle();
    checks++;
    if (cc_out !== 3'b010) begin
      errors++;
      $display("FAIL ckpt_restore cc=%b want 010", cc_out);
    end
    load(64'd0, 0);
    idle(); checkpoint = 1; restore = 1; tick(); idle();
    checks++;
    if (cc_out !== 3'b010) begin
      errors++;
      $display("FAIL ckpt_swap cc=%b want 010", cc_out);
    end
    idle(); restore = 1; tick(); idle();
    checks++;
    if (cc_out !== 3'b100) begin
      errors++;
      $display("FAIL ckpt_swap_shadow cc=%b want 100", cc_out);
    end
  endtask

  task automatic test_stall();
    logic [2:0] held;
    idle(); tick();
    held = cc_out;
    stall = 1; set_cc = 1; cnd_req = 1; cnd_ifun = 4'd0;
    alu_result = 64'd77; checkpoint = 1; restore = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (cc_out !== held || cnd_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d cc=%b valid=%b want cc=%b valid=0",
                 i, cc_out, cnd_valid, held);
      end
    end
    idle(); tick();
  endtask

  task automatic test_illegal();
    req(4'd9);
    checks++;
    if (cnd_valid !== 1'b1 || cnd !== 1'b0 || cnd_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal v=%b c=%b e=%b want 1 0 1",
               cnd_valid, cnd, cnd_err);
    end
    req(4'd0);
    checks++;
    if (cnd !== 1'b1 || cnd_err !== 1'b0) begin
      errors++;
      $display("FAIL legal_after c=%b e=%b want 1 0", cnd, cnd_err);
    end
    idle(); tick();
    checks++;
    if (cnd_valid !== 1'b0 || cnd !== 1'b1) begin
      errors++;
      $display("FAIL no_req_hold v=%b c=%b want 0 1", cnd_valid, cnd);
    end
  endtask

  task automatic test_bypass();
    logic want;
`ifdef CC_BYPASS_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    load(64'd0, 0);
    idle();
    set_cc = 1; alu_result = 64'd45; cnd_req = 1; cnd_ifun = 4'd4;
    tick(); idle();
    checks++;
    if (cnd !== want || cnd_valid !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ne cnd=%b valid=%b want %b 1",
               cnd, cnd_valid, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      idle();
      set_cc = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 3))
        0: alu_result = '0;
        1: alu_result = {$urandom(), $urandom()} | 64'h8000000000000000;
        default: alu_result = {1'b0, 31'($urandom()), $urandom()};
      endcase
      alu_overflow = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 7) == 0);
      checkpoint = ($urandom_range(0, 5) == 0);
      restore = ($urandom_range(0, 5) == 0);
      cnd_req = ($urandom_range(0, 2) != 0);
      cnd_ifun = 4'($urandom_range(0, 8));
      tick();
      checks++;
      if (cc_out !== m_cc || cnd_valid !== m_valid ||
          cnd !== m_cnd || cnd_err !== m_err) begin
        errors++;
        $display("FAIL rand_%0d got cc=%b v=%b c=%b e=%b want %b %b %b %b",
                 i, cc_out, cnd_valid, cnd, cnd_err,
                 m_cc, m_valid, m_cnd, m_err);
      end
    end
    idle(); tick();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_flags();
    test_checkpoint();
    test_stall();
    test_illegal();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_cc_unit.md
Name: y86_cc_unit

Overview:
- Condition-code unit for the Y86 execute stage; consumes the 64-bit ALU adder's `sum` and `overflow` outputs.
- Latches ZF/SF/OF into the CC register on `set_cc`.
- Evaluates jXX/cmovXX conditions on request and returns a registered `cnd` one cycle later.
- Keeps a one-deep checkpoint of CC so a squashed instruction can roll the flags back.

Parameters:
- WIDTH, 64, ALU result width in bits.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- alu_result  input  WIDTH  signed ALU sum/difference
- alu_overflow  input  1  ALU signed-overflow flag
- set_cc  input  1  load flags from ALU this cycle
- stall  input  1  freeze CC, checkpoint and response registers
- checkpoint  input  1  copy the current CC into the shadow register
- restore  input  1  copy the shadow register into CC
- cnd_req  input  1  condition evaluation request
- cnd_ifun  input  4  Y86 ifun of the requesting instruction
- cc_out  output  3  {ZF,SF,OF} current CC register
- cnd_valid  output  1  `cnd` response valid
- cnd  output  1  condition result
- cnd_err  output  1  ifun was illegal (>6)

Behaviour:
- Reset (async, immediate) values:
  - CC = CC_RESET; shadow = CC_RESET.
  - cnd_valid = 0, cnd = 0, cnd_err = 0.
- Flag derivation, all combinational from the ALU inputs:
  - ZF = (alu_result == 0)
  - SF = alu_result[WIDTH-1]
  - OF = alu_overflow
- CC update at the clock edge. Priority, evaluated only when `stall` = 0:
  - restore: CC <= shadow.
  - else set_cc: CC <= new flags.
  - else: hold.
- Checkpoint:
  - When `checkpoint` = 1 and `stall` = 0, shadow <= CC value before this edge's update.
  - checkpoint and restore in the same cycle: shadow <= old CC, CC <= old shadow, i.e. a swap.
- Stall: when `stall` = 1, CC, shadow, cnd, cnd_valid and cnd_err all hold; requests arriving during stall are dropped.
- Condition evaluation uses the CC register value before the edge (no bypass). Mapping by cnd_ifun:
  - 0: always 1
  - 1 (le): (SF^OF)|ZF
  - 2 (l): SF^OF
  - 3 (e): ZF
  - 4 (ne): ~ZF
  - 5 (ge): ~(SF^OF)
  - 6 (g): ~(SF^OF)&~ZF
  - 7–15: cnd = 0, cnd_err = 1
- Response timing:
  - Registered output; latency 1 cycle.
  - If cnd_req = 1 at edge N, then after edge N: cnd_valid = 1 and cnd/cnd_err hold the result.
  - cnd_valid is a single-cycle pulse per request; back-to-back requests give back-to-back pulses.
  - When there is no request, cnd_valid = 0 and cnd/cnd_err keep their last value.
- Simultaneous set_cc and cnd_req: the request sees the old flags.
- Reset asserted mid-request: the response is lost and cnd_valid stays 0.
- cc_out always reflects the CC register, never the bypass path.

Optional Feature:
- Macro: CC_BYPASS_EN.
- Defined:
  - A cnd_req in the same cycle as a non-stalled set_cc (and no restore) evaluates against the new ALU flags.
  - A request in the same cycle as a restore evaluates against the shadow.
  - This gives OPq-then-jXX zero-bubble behaviour.
- Undefined: evaluation always uses the registered CC; the pipeline must insert one bubble.

Decomposition:
- Shared package y86_pkg holds:
  - constants for ifun codes C_ALWAYS..C_G (0..6)
  - CC bit indices CC_ZF=2, CC_SF=1, CC_OF=0
  - typedef cc_t (3-bit)
- One natural sub-module, y86_cond_eval: combinational {cc, ifun} -> {cnd, err}. It is instantiated once, with its cc input muxed by CC_BYPASS_EN.

Test Plan:
- Reset: assert rst mid-cycle -> cc_out = 3'b100 immediately; cnd_valid = 0. Then a request with ifun = 3 returns cnd = 1 next cycle.
- Flag load:
  - set_cc with result -610, overflow 0 -> cc_out = 3'b010; ifun 2 -> cnd = 1; ifun 6 -> cnd = 0.
  - Result 0 -> cc_out = 3'b100.
  - Result 64'h579B579B579B579A with overflow 1 -> cc_out = 3'b001; ifun 5 -> cnd = 0.
- Checkpoint/restore:
  - Load 3'b010, checkpoint, then set_cc with result 20356 (cc = 3'b000).
  - restore -> cc_out = 3'b010.
  - Same-cycle checkpoint+restore swaps CC and shadow.
- Stall: hold stall with set_cc and cnd_req active for 3 cycles -> cc_out unchanged, cnd_valid = 0 throughout.
- Illegal ifun: ifun = 9 -> cnd_valid = 1, cnd = 0, cnd_err = 1. Next request ifun = 0 -> cnd = 1, cnd_err = 0.
- Bypass:
  - CC = 3'b100, same-cycle set_cc (result 45) + request ifun 4.
  - CC_BYPASS_EN defined -> cnd = 1.
  - Undefined -> cnd = 0.
